// File: rtl/char_pixel_gen.sv
// Text-mode scanline renderer: text RAM column -> char code -> font ROM slice -> serial pixels.
// Latency: first pixel is driven after the 8th tick following line_start; one pixel per tick after that.
// Backpressure: none. pix_en gates every register, so outputs freeze while it is low.
// Optional feature: define CURSOR_BLINK_EN to blink the cursor every BLINK_FRAMES frames.
module char_pixel_gen #(
  parameter int COLS         = 80,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [3:0]  row,
  output logic [6:0]  text_col,
  input  logic [7:0]  char_code,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [6:0]  cursor_col,
  input  logic        cursor_en,
  output logic        pixel,
  output logic        pixel_valid
);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE} state_t;

  // Compared against text_col before it is incremented, so COLS=128 never wraps early.
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_t      state, state_nxt;
  logic [2:0]  xpix;
  logic [7:0]  shreg;
  logic        fetch_done;  // last column has been loaded; no further fetches this line
  logic        blink_vis;
  logic        cursor_hit;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_hidden;

  // Count frames; flip the cursor phase each time the count wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (pix_en && frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_vis = ~blink_hidden;
`else
  // Without blinking the cursor is steady and frame_start has no use.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign blink_vis          = 1'b1;
`endif

  // text_col still names the column being loaded at the load event.
  assign cursor_hit = cursor_en && blink_vis && (text_col == cursor_col);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (pix_en) begin
      state <= state_nxt;
    end
  end

  // Next state: line_start always (re)starts; each load event moves to ACTIVE or ends the line.
  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = LEAD;
    end else if (state != IDLE && xpix == 3'd7) begin
      state_nxt = fetch_done ? IDLE : ACTIVE;
    end
  end

  // Fetch pipeline and shift register, advanced on ticks only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xpix        <= 3'd0;
      text_col    <= 7'd0;
      rom_addr    <= 12'd0;
      shreg       <= 8'd0;
      fetch_done  <= 1'b0;
      pixel_valid <= 1'b0;
    end else if (pix_en) begin
      if (line_start) begin
        xpix        <= 3'd0;
        text_col    <= 7'd0;
        shreg       <= 8'd0;
        fetch_done  <= 1'b0;
        pixel_valid <= 1'b0;
      end else if (state != IDLE) begin
        xpix <= xpix + 3'd1;
        if (xpix == 3'd7) begin
          if (fetch_done) begin
            // Last cell has shown all 8 pixels: close the line.
            text_col    <= 7'd0;
            shreg       <= 8'd0;
            fetch_done  <= 1'b0;
            pixel_valid <= 1'b0;
          end else begin
            shreg       <= rom_data ^ {8{cursor_hit}};
            pixel_valid <= 1'b1;
            if (text_col == LAST_COL) begin
              fetch_done <= 1'b1;
            end else begin
              text_col <= text_col + 7'd1;
            end
          end
        end else begin
          // char_code has had two ticks to settle after text_col moved, even with pix_en stuck high.
          if (xpix == 3'd2 && !fetch_done) begin
            rom_addr <= {char_code, row};
          end
          if (state == ACTIVE) begin
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Video output: MSB of the shift register, blanked outside visible cells.
  always_comb begin
    pixel = pixel_valid & shreg[7];
  end

endmodule

// File: tb/tb_char_pixel_gen.sv
// Bench for char_pixel_gen: registered text RAM / font ROM models, queued expected pixels,
// and a negedge monitor that consumes one expected pixel per visible tick.
module tb_char_pixel_gen;
  localparam int COLS         = 8;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_en;
  logic        line_start;
  logic        frame_start;
  logic [3:0]  row;
  logic [6:0]  text_col;
  logic [7:0]  char_code;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [6:0]  cursor_col;
  logic        cursor_en;
  logic        pixel;
  logic        pixel_valid;

  char_pixel_gen #(.COLS(COLS), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .line_start(line_start),
    .frame_start(frame_start), .row(row), .text_col(text_col), .char_code(char_code),
    .rom_addr(rom_addr), .rom_data(rom_data), .cursor_col(cursor_col),
    .cursor_en(cursor_en), .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:127];
  logic [7:0] rom [0:4095];

  always @(posedge clk) begin
    char_code <= ram[text_col];
    rom_data  <= rom[rom_addr];
  end

  int errors = 0;
  int checks = 0;
  bit exp_q[$];
  int vcnt = 0;
  int throttle = 1;
  int max_col;
  logic [11:0] last_addr;
  logic [11:0] addr_seq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every tick consumes the pixel currently on the output.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pix_en === 1'b1) begin
      if (pixel_valid === 1'b1) begin
        vcnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: got pixel %0b with nothing expected", pixel);
        end else begin
          bit e;
          e = exp_q.pop_front();
          if (pixel !== e) begin
            errors++;
            $display("FAIL pixel #%0d: got %0b expected %0b", vcnt, pixel, e);
          end
        end
      end else begin
        checks++;
        if (pixel !== 1'b0) begin
          errors++;
          $display("FAIL blank_pixel: got %0b expected 0", pixel);
        end
      end
    end
  end

  // One tick; with throttle>1 the preceding idle clocks must leave outputs frozen.
  task automatic do_tick(input bit ls, input bit fs);
    logic [20:0] snap;
    snap = {pixel, pixel_valid, text_col, rom_addr};
    for (int i = 1; i < throttle; i++) begin
      pix_en = 1'b0; line_start = ls; frame_start = fs;
      @(posedge clk); #1;
      chk("frozen", {11'd0, pixel, pixel_valid, text_col, rom_addr}, {11'd0, snap});
    end
    pix_en = 1'b1; line_start = ls; frame_start = fs;
    @(posedge clk); #1;
    pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    if (int'(text_col) > max_col) max_col = int'(text_col);
    if (rom_addr !== last_addr) begin
      addr_seq.push_back(rom_addr);
      last_addr = rom_addr;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Lead-in plus one full line, entered right after the line_start tick.
  task automatic line_body(input string tag);
    int v0;
    v0 = vcnt;
    chk({tag, " start_col"}, text_col, 0);
    chk({tag, " start_valid"}, pixel_valid, 0);
    for (int t = 1; t <= 8; t++) begin
      do_tick(1'b0, 1'b0);
      if (t == 7) chk({tag, " lead_valid"}, pixel_valid, 0);
    end
    chk({tag, " first_valid"}, pixel_valid, 1);
    for (int t = 0; t < COLS * 8; t++) do_tick(1'b0, 1'b0);
    chk({tag, " end_valid"}, pixel_valid, 0);
    chk({tag, " end_col"}, text_col, 0);
    chk({tag, " valid_ticks"}, vcnt - v0, COLS * 8);
    chk({tag, " queue_left"}, exp_q.size(), 0);
  endtask

  task automatic run_line(input string tag);
    max_col = 0;
    addr_seq.delete();
    last_addr = rom_addr;
    do_tick(1'b1, 1'b0);
    line_body(tag);
  endtask

  task automatic fill_mem(input logic [7:0] ch);
    for (int i = 0; i < 128; i++) ram[i] = ch;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic push_single_char_line();
    push_byte(8'h7E);
    for (int c = 1; c < COLS; c++) push_byte(8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", {12'd0, pixel, pixel_valid, text_col, rom_addr}, 32'd0);
    exp_q.delete();
    #10;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    row = 4'd3; cursor_col = 7'd0; cursor_en = 1'b0;
    char_code = 8'd0; rom_data = 8'd0;
    fill_mem(8'h20);
    #12;
    chk("reset_state", {12'd0, pixel, pixel_valid, text_col, rom_addr}, 32'd0);
    #11;
    reset_n = 1'b1;

    // Single character, pix_en held high.
    ram[0] = 8'h41; rom[12'h413] = 8'h7E; row = 4'd3;
    push_single_char_line();
    run_line("single");
    chk("single rom_addr", (addr_seq.size() > 0) ? 32'(addr_seq[0]) : 32'hFFFF, 32'h413);
    chk("single max_col", max_col, COLS - 1);

    // Same data with one tick every 4 clocks.
    throttle = 4;
    push_single_char_line();
    run_line("throttled");
    throttle = 1;

    // Cursor on column 5 over an all-blank font.
    fill_mem(8'h20);
    cursor_en = 1'b1; cursor_col = 7'd5;
    for (int i = 0; i < COLS * 8; i++) exp_q.push_back(i >= 40 && i <= 47);
    run_line("cursor");
    cursor_en = 1'b0;

    // Distinct characters across the whole line; addresses must step once per column.
    fill_mem(8'h7F);
    row = 4'd5;
    for (int c = 0; c < COLS; c++) begin
      ram[c] = 8'h30 + 8'(c);
      rom[{8'h30 + 8'(c), 4'd5}] = 8'h81 ^ (8'(c) * 8'h11);
      push_byte(8'h81 ^ (8'(c) * 8'h11));
    end
    run_line("wrap");
    chk("wrap addr_count", addr_seq.size(), COLS);
    for (int c = 0; c < COLS; c++)
      chk("wrap rom_addr", (c < addr_seq.size()) ? 32'(addr_seq[c]) : 32'hFFFF, 32'h305 + 32'(c) * 32'h10);
    chk("wrap max_col", max_col, COLS - 1);

    // Abort: restart on visible pixel index 20.
    fill_mem(8'h20);
    ram[0] = 8'h41; rom[12'h413] = 8'h7E; row = 4'd3;
    push_byte(8'h7E);
    for (int i = 8; i <= 20; i++) exp_q.push_back(1'b0);
    push_single_char_line();
    do_tick(1'b1, 1'b0);
    for (int t = 1; t <= 28; t++) do_tick(1'b0, 1'b0);
    chk("abort before", pixel_valid, 1);
    do_tick(1'b1, 1'b0);
    chk("abort valid_drop", pixel_valid, 0);
    line_body("abort");

    // Reset in the middle of a line, then a clean line.
    push_single_char_line();
    do_tick(1'b1, 1'b0);
    for (int t = 1; t <= 12; t++) do_tick(1'b0, 1'b0);
    do_reset();
    push_single_char_line();
    run_line("after_reset");

    // Cursor on column 0 across five frames.
    do_reset();
    fill_mem(8'h20);
    cursor_en = 1'b1; cursor_col = 7'd0; row = 4'd0;
    for (int f = 0; f < 5; f++) begin
      bit inv;
`ifdef CURSOR_BLINK_EN
      inv = ((f / BLINK_FRAMES) % 2) == 0;
`else
      inv = 1'b1;
`endif
      push_byte(inv ? 8'hFF : 8'h00);
      for (int c = 1; c < COLS; c++) push_byte(8'h00);
      run_line("blink");
      do_tick(1'b0, 1'b1);
    end
    cursor_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
